// File: rtl/cpu_step_controller_pkg.sv
// rtl/cpu_step_controller_pkg.sv - shared types and defaults for the CPU step controller
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      STEP_WAIT = 2'd2,
      HALTED    = 2'd3
   } step_state_t;

   localparam int COUNT_W_DEFAULT = 16;

endpackage

// File: rtl/cpu_step_controller_if.sv
// rtl/cpu_step_controller_if.sv - control/status bundle of the CPU step controller
// Optional BreakCount member exists only when STEP_BREAK_EN is defined.
interface cpu_step_controller_if
   import cpu_ctrl_pkg::*;
#(
   parameter int COUNT_W = COUNT_W_DEFAULT
);
   logic               Enable;
   logic               RunBtn;
   logic               StepBtn;
   logic               Halt;
   logic               ClearHalt;
   logic               CpuStep;
   logic               Running;
   logic               Halted;
   logic [COUNT_W-1:0] StepCount;
`ifdef STEP_BREAK_EN
   logic [COUNT_W-1:0] BreakCount;
`endif

   modport master (
`ifdef STEP_BREAK_EN
      output BreakCount,
`endif
      output Enable, RunBtn, StepBtn, Halt, ClearHalt,
      input  CpuStep, Running, Halted, StepCount
   );

   modport slave (
`ifdef STEP_BREAK_EN
      input  BreakCount,
`endif
      input  Enable, RunBtn, StepBtn, Halt, ClearHalt,
      output CpuStep, Running, Halted, StepCount
   );

endinterface

// File: rtl/cpu_step_controller_button_edge.sv
// rtl/cpu_step_controller_button_edge.sv - registered rising-edge detector for a raw button level
module button_edge (
   input  logic ClockIn,
   input  logic Resetn,
   input  logic Level,
   output logic Pulse
);

   logic level_q;
   logic prev_q;

   // Level is registered before edge detection so the FSM never sees the raw pin directly.
   always_ff @(posedge ClockIn) begin
      if (!Resetn) begin
         level_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         level_q <= Level;
         prev_q  <= level_q;
      end
   end

   assign Pulse = level_q & ~prev_q;

endmodule

// File: rtl/cpu_step_controller.sv
// rtl/cpu_step_controller.sv - turns rate-divider ticks into CPU step strobes with run/step/halt control
// Optional auto-pause on BreakCount is built when STEP_BREAK_EN is defined.
module cpu_step_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int COUNT_W = COUNT_W_DEFAULT
) (
   input  logic                   ClockIn,
   input  logic                   Resetn,
   cpu_step_controller_if.slave   bus
);

   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

   step_state_t        state;
   step_state_t        state_next;
   logic               step_next;
   logic               step_q;
   logic               running_q;
   logic               halted_q;
   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] count_inc;
   logic               break_hit;
   logic               run_edge;
   logic               step_edge;

   button_edge u_run_edge (
      .ClockIn (ClockIn),
      .Resetn  (Resetn),
      .Level   (bus.RunBtn),
      .Pulse   (run_edge)
   );

   button_edge u_step_edge (
      .ClockIn (ClockIn),
      .Resetn  (Resetn),
      .Level   (bus.StepBtn),
      .Pulse   (step_edge)
   );

   assign count_inc = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_W'(1);

`ifdef STEP_BREAK_EN
   // Compared against the post-increment value so the breaking step itself still goes out.
   assign break_hit = (bus.BreakCount != '0) && (count_inc == bus.BreakCount);
`else
   assign break_hit = 1'b0;
`endif

   always_comb begin
      state_next = state;
      step_next  = 1'b0;
      if (bus.Halt) begin
         state_next = HALTED;
      end else begin
         case (state)
            IDLE: begin
               if (run_edge)       state_next = RUN;
               else if (step_edge) state_next = STEP_WAIT;
            end
            RUN: begin
               step_next = bus.Enable;
               if (run_edge || (bus.Enable && break_hit)) state_next = IDLE;
            end
            STEP_WAIT: begin
               step_next = bus.Enable;
               if (run_edge)        state_next = RUN;
               else if (bus.Enable) state_next = IDLE;
            end
            HALTED: begin
               if (bus.ClearHalt) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge ClockIn) begin
      if (!Resetn) begin
         state     <= IDLE;
         step_q    <= 1'b0;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
         count_q   <= '0;
      end else begin
         state     <= state_next;
         step_q    <= step_next;
         running_q <= (state_next == RUN);
         halted_q  <= (state_next == HALTED);
         if (step_next) count_q <= count_inc;
      end
   end

   assign bus.CpuStep   = step_q;
   assign bus.Running   = running_q;
   assign bus.Halted    = halted_q;
   assign bus.StepCount = count_q;

endmodule
